// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition codes, NZCV flag bit
// positions and FlagW write-select bit positions.
package arm_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGW_W = 2;

  // NZCV bit positions, shared with the ALU flag output
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // FlagW bits: NZ half and CV half
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

endpackage

// File: rtl/cond_check.sv
// Condition-code decode table.
// Ports:
//   Cond   - instruction condition field
//   Flags  - registered NZCV
//   CondEx - 1 when the condition passes (NV never passes)
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      EQ:      CondEx = z;
      NE:      CondEx = ~z;
      CS:      CondEx = c;
      CC:      CondEx = ~c;
      MI:      CondEx = n;
      PL:      CondEx = ~n;
      VS:      CondEx = v;
      VC:      CondEx = ~v;
      HI:      CondEx = c & ~z;
      LS:      CondEx = ~c | z;
      GE:      CondEx = ~(n ^ v);
      LT:      CondEx = n ^ v;
      GT:      CondEx = ~z & ~(n ^ v);
      LE:      CondEx = z | (n ^ v);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV register, evaluates the
// instruction condition against it and gates the decoder write enables.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   Cond              - condition field instr[31:28]
//   ALUFlags          - NZCV from the ALU for the current instruction
//   FlagW             - [1] write N,Z  [0] write C,V
//   PCS, RegW, MemW   - decoder write requests
//   NoWrite           - suppress register write (compare/test ops)
//   PCSrc, RegWrite, MemWrite - condition-gated enables (combinational)
//   Flags             - registered NZCV
//   CondEx            - condition passed for the current instruction
module cond_logic
  import arm_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q;

  // Condition is evaluated against the registered flags only, so an
  // instruction's own flag update never affects its own condition.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  // NZCV register; each half loads independently when the condition passes
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
    end else if (CondEx) begin
      if (FlagW[FW_NZ]) begin
        flags_q[FLAG_N] <= ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[FW_CV]) begin
        flags_q[FLAG_C] <= ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  assign Flags = flags_q;

  // Write enables are held low throughout reset
  assign PCSrc    = PCS  & CondEx & ~reset;
  assign RegWrite = RegW & CondEx & ~NoWrite & ~reset;
  assign MemWrite = MemW & CondEx & ~reset;

endmodule
